// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution control path.
package conv_pkg;

    typedef enum logic [3:0] {
        IDLE, INIT, LOAD_F, OFS_CLR, LOAD_MB, LOAD_WB,
        MAC, ACC, CHK, WRITE, SHIFT, FIN
    } state_t;

    localparam logic [1:0] SEL_FILTER = 2'b00;
    localparam logic [1:0] SEL_IMAGE  = 2'b01;
    localparam logic [1:0] SEL_RESULT = 2'b10;

    // The datapath raises raDone on the last of these taps.
    localparam int MAC_TAPS = 16;

    typedef struct packed {
        logic [1:0] base_addr_sel;
        logic [1:0] offset_mode;
        logic       offset_act;
        logic       offset_rst;
        logic       mem_ren;
        logic       mem_wen;
        logic       fbl_rst;
        logic       fbl_act;
        logic       fil_buf_rst;
        logic       fil_buf_ld;
        logic       fill_buf_isel;
        logic       mb_rst;
        logic       mb_shift;
        logic       mb_write;
        logic       mbl_rst;
        logic       mbl_act;
        logic       mbc_rst;
        logic       mbc_en;
        logic       wb_rst;
        logic       wb_ld;
        logic       ra_act;
        logic       mac_rst;
        logic       mac_act;
        logic       mac_clear;
        logic       rb_rst;
        logic       rb_en;
        logic       rb_clear;
        logic       busy;
        logic       done;
    } ctrl_t;

    // Quiescent strobe set: everything low, address/mode pointing at the image.
    function automatic ctrl_t ctrl_default();
        ctrl_t c;
        c               = '0;
        c.base_addr_sel = SEL_IMAGE;
        c.offset_mode   = SEL_IMAGE;
        return c;
    endfunction

endpackage

// File: rtl/beat_counter.sv
// Memory-beat counter for the load states; wrap marks the last beat.
module beat_counter #(
    parameter int LOAD_BEATS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic wrap
);

    localparam int CW = (LOAD_BEATS > 1) ? $clog2(LOAD_BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(LOAD_BEATS - 1);

    logic [CW-1:0] cnt;

    assign wrap = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= wrap ? '0 : cnt + CW'(1);
    end

endmodule

// File: rtl/conv_controller.sv
// Run sequencer for the convolution datapath: filter load, buffer fill,
// windowed 16-tap MAC, result collection/write-back and window shift.
module conv_controller
    import conv_pkg::*;
#(
    parameter int LOAD_BEATS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       offsetDone,
    input  logic       mbcZero,
    input  logic       raDone,
    input  logic       rbFull,
    output logic [1:0] baseAddrSel,
    output logic [1:0] offsetMode,
    output logic       offsetAct,
    output logic       offsetRst,
    output logic       memREn,
    output logic       memWEn,
    output logic       fblRst,
    output logic       fblAct,
    output logic       filBufRst,
    output logic       filBufLd,
    output logic       fillBufISel,
    output logic       mbRst,
    output logic       mbShift,
    output logic       mbWrite,
    output logic       mblRst,
    output logic       mblAct,
    output logic       mbcRst,
    output logic       mbcEn,
    output logic       wbRst,
    output logic       wbLd,
    output logic       raAct,
    output logic       macRst,
    output logic       macAct,
    output logic       macClear,
    output logic       rbRst,
    output logic       rbEn,
    output logic       rbClear,
    output logic       busy,
    output logic       done
);

    state_t state, state_nx;
    ctrl_t  ctrl;
    logic   beat_wrap;
    logic   beat_en;
    logic   beat_clr;

    // Counter runs only in the two load states and restarts on every entry.
    assign beat_en  = (state == LOAD_F) || (state == LOAD_MB);
    assign beat_clr = (state_nx != state) && ((state_nx == LOAD_F) || (state_nx == LOAD_MB));

    beat_counter #(.LOAD_BEATS(LOAD_BEATS)) u_beat (
        .clk  (clk),
        .rst  (rst),
        .clr  (beat_clr),
        .en   (beat_en),
        .wrap (beat_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        ctrl      = ctrl_default();
        ctrl.busy = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) state_nx = INIT;
            end
            INIT: begin
                ctrl.offset_rst  = 1'b1;
                ctrl.fbl_rst     = 1'b1;
                ctrl.fil_buf_rst = 1'b1;
                ctrl.mb_rst      = 1'b1;
                ctrl.mbl_rst     = 1'b1;
                ctrl.mbc_rst     = 1'b1;
                ctrl.wb_rst      = 1'b1;
                ctrl.mac_rst     = 1'b1;
                ctrl.rb_rst      = 1'b1;
                state_nx         = LOAD_F;
            end
            LOAD_F: begin
                ctrl.base_addr_sel = SEL_FILTER;
                ctrl.offset_mode   = SEL_FILTER;
                ctrl.mem_ren       = 1'b1;
                ctrl.offset_act    = 1'b1;
                ctrl.fil_buf_ld    = 1'b1;
                ctrl.fill_buf_isel = 1'b1;
                ctrl.fbl_act       = 1'b1;
                if (beat_wrap) state_nx = OFS_CLR;
            end
            OFS_CLR: begin
                // Filter and image share one offset generator; rewind it.
                ctrl.offset_rst = 1'b1;
                state_nx        = LOAD_MB;
            end
            LOAD_MB: begin
                ctrl.mem_ren    = 1'b1;
                ctrl.offset_act = 1'b1;
                ctrl.mb_write   = 1'b1;
                ctrl.mbl_act    = 1'b1;
                if (beat_wrap) state_nx = LOAD_WB;
            end
            LOAD_WB: begin
                ctrl.wb_ld = 1'b1;
                state_nx   = MAC;
            end
            MAC: begin
                ctrl.ra_act  = 1'b1;
                ctrl.mac_act = 1'b1;
                if (raDone) state_nx = ACC;
            end
            ACC: begin
                ctrl.rb_en     = 1'b1;
                ctrl.mac_clear = 1'b1;
                state_nx       = CHK;
            end
            CHK: begin
                // Flush pending results before honouring end-of-image.
                if (rbFull)          state_nx = WRITE;
                else if (offsetDone) state_nx = FIN;
                else if (mbcZero)    state_nx = LOAD_MB;
                else                 state_nx = SHIFT;
            end
            WRITE: begin
                ctrl.base_addr_sel = SEL_RESULT;
                ctrl.offset_mode   = SEL_RESULT;
                ctrl.mem_wen       = 1'b1;
                ctrl.offset_act    = 1'b1;
                ctrl.rb_clear      = 1'b1;
                state_nx           = CHK;
            end
            SHIFT: begin
                ctrl.mb_shift = 1'b1;
                ctrl.mbc_en   = 1'b1;
                state_nx      = LOAD_WB;
            end
            FIN: begin
                ctrl.done = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign baseAddrSel = ctrl.base_addr_sel;
    assign offsetMode  = ctrl.offset_mode;
    assign offsetAct   = ctrl.offset_act;
    assign offsetRst   = ctrl.offset_rst;
    assign memREn      = ctrl.mem_ren;
    assign memWEn      = ctrl.mem_wen;
    assign fblRst      = ctrl.fbl_rst;
    assign fblAct      = ctrl.fbl_act;
    assign filBufRst   = ctrl.fil_buf_rst;
    assign filBufLd    = ctrl.fil_buf_ld;
    assign fillBufISel = ctrl.fill_buf_isel;
    assign mbRst       = ctrl.mb_rst;
    assign mbShift     = ctrl.mb_shift;
    assign mbWrite     = ctrl.mb_write;
    assign mblRst      = ctrl.mbl_rst;
    assign mblAct      = ctrl.mbl_act;
    assign mbcRst      = ctrl.mbc_rst;
    assign mbcEn       = ctrl.mbc_en;
    assign wbRst       = ctrl.wb_rst;
    assign wbLd        = ctrl.wb_ld;
    assign raAct       = ctrl.ra_act;
    assign macRst      = ctrl.mac_rst;
    assign macAct      = ctrl.mac_act;
    assign macClear    = ctrl.mac_clear;
    assign rbRst       = ctrl.rb_rst;
    assign rbEn        = ctrl.rb_en;
    assign rbClear     = ctrl.rb_clear;
    assign busy        = ctrl.busy;
    assign done        = ctrl.done;

endmodule

// File: doc/conv_controller.md
# conv_controller

Control FSM for the convolution datapath. It sits directly upstream of the datapath and drives every datapath control strobe. It consumes the datapath status flags `offsetDone`, `mbcZero`, `raDone` and `rbFull`. It sequences a whole run: filter load, middle-buffer fill, window load, 16-tap MAC, result collection, result write-back and window shift.

## Interface
- `LOAD_BEATS`, default 4: memory beats per filter load and per middle-buffer fill, one row per beat.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  run request; sampled only in IDLE.
- `offsetDone`, `mbcZero`, `raDone`, `rbFull`  in  1 each  datapath status flags.
- `baseAddrSel`, `offsetMode`  out  2 each  00 = filter (x), 01 = image (y), 10 = result (z).
- `offsetAct`, `offsetRst`, `memREn`, `memWEn`, `fblRst`, `fblAct`, `filBufRst`, `filBufLd`, `fillBufISel`  out  1 each  datapath strobes.
- `mbRst`, `mbShift`, `mbWrite`, `mblRst`, `mblAct`, `mbcRst`, `mbcEn`, `wbRst`, `wbLd`, `raAct`, `macRst`, `macAct`, `macClear`, `rbRst`, `rbEn`, `rbClear`  out  1 each  datapath strobes.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on run completion.

## Operation
- Moore machine: all outputs are decoded from the state register and the beat counter only.
- Any output not listed for a state is 0. `baseAddrSel` and `offsetMode` default to 01.
- Internal beat counter is `$clog2(LOAD_BEATS)` bits. It is cleared on entry to each load state and wraps to 0 after `LOAD_BEATS-1`.
- IDLE: if `start`=1, go to INIT.
- INIT, 1 cycle: `offsetRst`, `fblRst`, `filBufRst`, `mbRst`, `mblRst`, `mbcRst`, `wbRst`, `macRst`, `rbRst` all high. Go to LOAD_F.
- LOAD_F, `LOAD_BEATS` cycles:
  - `baseAddrSel`=`offsetMode`=00.
  - `memREn`, `offsetAct`, `filBufLd`, `fillBufISel`, `fblAct` high.
  - Then `offsetRst` is pulsed for 1 cycle (state OFS_CLR, mode 01), then go to LOAD_MB.
- LOAD_MB, `LOAD_BEATS` cycles: mode 01; `memREn`, `offsetAct`, `mbWrite`, `mblAct` high. Go to LOAD_WB.
- LOAD_WB, 1 cycle: `wbLd` high. Go to MAC.
- MAC: `raAct`, `macAct` high until `raDone` is sampled 1, then go to ACC. `raDone` is high on the 16th cycle.
- ACC, 1 cycle: `rbEn`, `macClear` high. Go to CHK.
- CHK, 1 cycle, mode 01, no strobes. Priority order:
  - `rbFull` → WRITE;
  - else `offsetDone` → FIN;
  - else `mbcZero` → LOAD_MB;
  - else → SHIFT.
- WRITE, 1 cycle: `baseAddrSel`=`offsetMode`=10; `memWEn`, `offsetAct`, `rbClear` high. Go to CHK.
- SHIFT, 1 cycle: `mbShift`, `mbcEn` high. Go to LOAD_WB.
- FIN, 1 cycle: `done`=1. Go to IDLE.

## Timing
- Reset: state is IDLE, beat counter is 0, and every output is 0 except `baseAddrSel`=`offsetMode`=01. This holds until the first clock edge after `rst` falls.
- `start` sampled high at edge N gives INIT during cycle N+1.
- Nominal first window: LOAD_F cycles N+2..N+5, OFS_CLR N+6, LOAD_MB N+7..N+10, LOAD_WB N+11, MAC N+12..N+27, ACC N+28, CHK N+29.
- `start` while `busy`=1 is ignored; no restart and no queuing.
- A `start` held high through FIN starts a new run on the cycle after `done`.
- `raDone` never seen: stay in MAC indefinitely. No timeout.
- `rbFull` and `offsetDone` both 1 in CHK: WRITE first. The pending results are flushed before FIN.
- `rst` mid-run, in any state: immediate return to IDLE with reset output values. No `done` pulse.

## Structure
- Shared package `conv_pkg`:
  - `state_t` enum: IDLE, INIT, LOAD_F, OFS_CLR, LOAD_MB, LOAD_WB, MAC, ACC, CHK, WRITE, SHIFT, FIN.
  - Select/mode constants `SEL_FILTER`=2'b00, `SEL_IMAGE`=2'b01, `SEL_RESULT`=2'b10.
  - `MAC_TAPS`=16.
- One sub-module: `beat_counter`, with clear, enable, a wrap flag on `LOAD_BEATS-1` and a reset-to-0.

## Test plan
- Reset: assert `rst` with no clock → all strobes 0, `busy`=0, `baseAddrSel`=01.
- Single window: `start` at cycle 0 with `raDone` driven on the 16th MAC cycle, `rbFull`=0, `mbcZero`=0 → `rbEn` at cycle 28, then SHIFT then `wbLd` at cycles 30/31.
- Write-back: `rbFull`=1 in CHK → exactly one `memWEn`+`rbClear` cycle with `baseAddrSel`=10, then CHK again.
- Row refill: `mbcZero`=1 in CHK → 4 cycles of `mbWrite`+`memREn` with mode 01, then `wbLd`.
- Termination: `offsetDone`=1 and `rbFull`=1 together in CHK → WRITE, CHK, then a 1-cycle `done`, then `busy`=0.
- Reset mid-MAC at cycle 20 → `raAct`/`macAct` drop asynchronously, and `start` 2 cycles later produces INIT.
